fft_agu_ctrl: RTL and testbench

Sequencer for the in-place radix-2 FFT address generation path. It accepts a frame of 2^M samples into the working memory in bit-reversed order. It then steps the butterfly address calculator through every (level, index) pair, one butterfly per cycle, and produces delayed write-back controls matched to the butterfly pipeline latency. It sits between the tuner's sample front end and the FFT memory/butterfly datapath, and signals completion to the peak-search logic.

---
 rtl/fft_agu_ctrl.sv | 151 +++++++++++++++
 tb/tb_fft_agu_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fft_agu_ctrl.sv
// Frame sequencer for the in-place radix-2 FFT: bit-reversed load, level/index
// stepping with inter-level drain, and write-back controls delayed by the butterfly latency.
module fft_agu_ctrl #(
  parameter int M        = 9,
  parameter int BFLY_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  output logic         load_we,
  output logic [M-1:0] load_adr,
  output logic [M-1:0] level,
  output logic [M-1:0] index,
  output logic         rd_en,
  output logic         rd_bank,
  output logic         wr_en,
  output logic [M-1:0] wb_level,
  output logic [M-1:0] wb_index,
  output logic         wb_bank,
  output logic         busy,
  output logic         done
);

  localparam int DW = (BFLY_LAT < 2) ? 1 : $clog2(BFLY_LAT);
  localparam int PW = 2 * M + 2;
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(BFLY_LAT - 1);
  localparam logic [M-1:0]   LAST_LEVEL = M'(M - 1);
  localparam logic [M-1:0]   ONE_M      = M'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [M-1:0]    load_cnt;
  logic [DW-1:0]   drain_cnt;
  logic [PW-1:0]   pipe [BFLY_LAT];

  function automatic logic [M-1:0] bit_rev(input logic [M-1:0] v);
    logic [M-1:0] r;
    for (int i = 0; i < M; i++) r[i] = v[M-1-i];
    return r;
  endfunction

  // The sample write strobe must coincide with the in_valid cycle itself.
  always_comb begin
    load_we  = 1'b0;
    load_adr = '0;
    if (state == S_LOAD) begin
      load_we  = in_valid;
      load_adr = bit_rev(load_cnt);
    end else begin
      load_we  = 1'b0;
      load_adr = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      drain_cnt <= '0;
      level     <= '0;
      index     <= '0;
      rd_en     <= 1'b0;
      rd_bank   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_LOAD;
            load_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            load_cnt <= load_cnt + ONE_M;
            if (load_cnt == {M{1'b1}}) begin
              state   <= S_COMPUTE;
              level   <= '0;
              index   <= '0;
              rd_en   <= 1'b1;
              rd_bank <= 1'b0;
            end
          end
        end
        S_COMPUTE: begin
          // Index is held on the final butterfly so its MSB never sets.
          if (index[M-2:0] == {(M-1){1'b1}}) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
            rd_en     <= 1'b0;
          end else begin
            index <= index + ONE_M;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DRAIN_LAST) begin
            if (level == LAST_LEVEL) begin
              state   <= S_DONE;
              level   <= '0;
              index   <= '0;
              rd_bank <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state   <= S_COMPUTE;
              level   <= level + ONE_M;
              index   <= '0;
              rd_en   <= 1'b1;
              rd_bank <= ~level[0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          rd_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back delay line; bank is qualified by rd_en so idle cycles shift in zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BFLY_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {rd_en, level, index, rd_en & ~rd_bank};
      for (int i = 1; i < BFLY_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {wr_en, wb_level, wb_index, wb_bank} = pipe[BFLY_LAT-1];

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Directed bench for fft_agu_ctrl: an M=3 instance for exact cycle-by-cycle
// sequencing and an M=9 instance for full-frame counts and mid-frame reset.
module tb_fft_agu_ctrl;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  logic       rst3, start3, iv3;
  logic       load_we3, rd_en3, rd_bank3, wr_en3, wb_bank3, busy3, done3;
  logic [2:0] load_adr3, level3, index3, wb_level3, wb_index3;

  logic       rst9, start9, iv9;
  logic       load_we9, rd_en9, rd_bank9, wr_en9, wb_bank9, busy9, done9;
  logic [8:0] load_adr9, level9, index9, wb_level9, wb_index9;

  fft_agu_ctrl #(.M(3), .BFLY_LAT(2)) u3 (
    .clk(clk), .reset(rst3), .start(start3), .in_valid(iv3),
    .load_we(load_we3), .load_adr(load_adr3), .level(level3), .index(index3),
    .rd_en(rd_en3), .rd_bank(rd_bank3), .wr_en(wr_en3), .wb_level(wb_level3),
    .wb_index(wb_index3), .wb_bank(wb_bank3), .busy(busy3), .done(done3)
  );

  fft_agu_ctrl #(.M(9), .BFLY_LAT(2)) u9 (
    .clk(clk), .reset(rst9), .start(start9), .in_valid(iv9),
    .load_we(load_we9), .load_adr(load_adr9), .level(level9), .index(index9),
    .rd_en(rd_en9), .rd_bank(rd_bank9), .wr_en(wr_en9), .wb_level(wb_level9),
    .wb_index(wb_index9), .wb_bank(wb_bank9), .busy(busy9), .done(done9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [10:0] pat;
    logic [2:0]  adr_tab [8];
    int k, lv, ph, wl, wp;
    int ld_cnt, rd_cnt, wr_cnt, done_cnt, done_c, first_rd, align_err, extra;
    int first_rd_lvl [9];
    int last_wr_lvl  [9];
    logic [20:0] prev1, prev2;
    bit found;

    adr_tab[0] = 3'd0; adr_tab[1] = 3'd4; adr_tab[2] = 3'd2; adr_tab[3] = 3'd6;
    adr_tab[4] = 3'd1; adr_tab[5] = 3'd5; adr_tab[6] = 3'd3; adr_tab[7] = 3'd7;
    pat = 11'b11011101101;  // read LSB first: 1,0,1,1,0,1,1,1,0,1,1

    rst3 = 1'b1; rst9 = 1'b1; start3 = 1'b0; iv3 = 1'b0; start9 = 1'b0; iv9 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_flags3", {25'd0, busy3, rd_en3, wr_en3, done3, load_we3, rd_bank3, wb_bank3}, 32'd0);
    check("rst_vecs3", {17'd0, load_adr3, level3, index3, wb_level3, wb_index3}, 32'd0);
    check("rst_flags9", {25'd0, busy9, rd_en9, wr_en9, done9, load_we9, rd_bank9, wb_bank9}, 32'd0);
    @(negedge clk);
    rst3 = 1'b0; rst9 = 1'b0;

    // ---------------- M=3: load ordering with gaps ----------------
    @(negedge clk);
    start3 = 1'b1;
    #1 check("idle_busy", {31'd0, busy3}, 32'd0);
    @(negedge clk);
    start3 = 1'b0;
    #1 check("load_busy", {31'd0, busy3}, 32'd1);
    k = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      iv3    = pat[c];
      start3 = (c == 1);
      #1;
      check("load_we", {31'd0, load_we3}, {31'd0, iv3});
      check("load_rd_en", {31'd0, rd_en3}, 32'd0);
      if (iv3) begin
        check("load_adr", {29'd0, load_adr3}, {29'd0, adr_tab[k]});
        k++;
      end
    end

    // ---------------- M=3: sequencing and write-back ----------------
    for (int t = 0; t < 21; t++) begin
      @(negedge clk);
      iv3    = 1'b0;
      start3 = (t == 5) || (t == 19);
      #1;
      lv = t / 6; ph = t % 6;
      if (t < 18) begin
        check("seq_rd_en", {31'd0, rd_en3}, {31'd0, ph < 4});
        if (ph < 4)
          check("seq_lvl_idx_bank", {25'd0, level3, index3, rd_bank3},
                {25'd0, 3'(lv), 3'(ph), 1'(lv % 2)});
      end else begin
        check("post_rd_en", {31'd0, rd_en3}, 32'd0);
      end
      wl = (t - 2) / 6; wp = (t - 2) % 6;
      if (t >= 2 && t < 20 && wp < 4) begin
        check("wb_en", {31'd0, wr_en3}, 32'd1);
        check("wb_fields", {25'd0, wb_level3, wb_index3, wb_bank3},
              {25'd0, 3'(wl), 3'(wp), 1'((wl + 1) % 2)});
      end else begin
        check("wb_idle", {31'd0, wr_en3}, 32'd0);
      end
      check("seq_done", {31'd0, done3}, {31'd0, t == 18});
      check("seq_busy", {31'd0, busy3}, {31'd0, (t < 18) || (t == 20)});
    end
    start3 = 1'b0;

    // ---------------- M=9: full frame ----------------
    @(negedge clk);
    start9 = 1'b1;
    @(negedge clk);
    start9 = 1'b0;
    ld_cnt = 0;
    for (int j = 0; j < 512; j++) begin
      @(negedge clk);
      iv9 = 1'b1;
      #1;
      ld_cnt += int'(load_we9);
      if (j == 1)   check("m9_adr1", {23'd0, load_adr9}, 32'd256);
      if (j == 6)   check("m9_adr6", {23'd0, load_adr9}, 32'd192);
      if (j == 511) check("m9_adr511", {23'd0, load_adr9}, 32'd511);
    end
    for (int l = 0; l < 9; l++) begin first_rd_lvl[l] = -1; last_wr_lvl[l] = -1; end
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_c = -100; first_rd = -1; align_err = 0;
    prev1 = '0; prev2 = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      iv9 = 1'b0;
      #1;
      if (rd_en9) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
        if (first_rd_lvl[level9] < 0) first_rd_lvl[level9] = c;
      end
      if (wr_en9 !== prev2[20]) align_err++;
      if (wr_en9) begin
        wr_cnt++;
        last_wr_lvl[wb_level9] = c;
        if ({wb_level9, wb_index9, wb_bank9} !== prev2[18:0]) align_err++;
      end
      if (done9) begin done_cnt++; done_c = c; end
      prev2 = prev1;
      prev1 = {rd_en9, 1'b0, level9, index9, rd_en9 & ~rd_bank9};
      if (done_cnt > 0 && c >= done_c + 3) break;
    end
    check("m9_loads", ld_cnt, 32'd512);
    check("m9_first_rd", first_rd, 32'd0);
    check("m9_rd_cnt", rd_cnt, 32'd2304);
    check("m9_wr_cnt", wr_cnt, 32'd2304);
    check("m9_done_cnt", done_cnt, 32'd1);
    check("m9_span", done_c - first_rd, 32'd2322);
    check("m9_align", align_err, 32'd0);
    check("m9_busy_after", {31'd0, busy9}, 32'd0);
    for (int l = 1; l < 9; l++)
      check("m9_no_hazard", {31'd0, first_rd_lvl[l] > last_wr_lvl[l-1]}, 32'd1);

    // ---------------- M=9: reset mid-COMPUTE ----------------
    @(negedge clk);
    start9 = 1'b1;
    @(negedge clk);
    start9 = 1'b0;
    for (int j = 0; j < 512; j++) begin
      @(negedge clk);
      iv9 = 1'b1;
    end
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      iv9 = 1'b0;
      #1;
      if (rd_en9 && level9 == 9'd3 && index9 == 9'd100) begin found = 1'b1; break; end
    end
    check("rst_target_found", {31'd0, found}, 32'd1);
    #1 rst9 = 1'b1;
    #1;
    check("async_rst_flags", {25'd0, busy9, rd_en9, wr_en9, done9, load_we9, rd_bank9, wb_bank9}, 32'd0);
    check("async_rst_lvl_idx", {14'd0, level9, index9}, 32'd0);
    check("async_rst_wb", {14'd0, wb_level9, wb_index9}, 32'd0);
    @(negedge clk);
    rst9 = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      extra += int'(wr_en9) + int'(rd_en9) + int'(busy9) + int'(done9);
    end
    check("post_rst_quiet", extra, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
